// File: rtl/shift_add_mult_ctrl.sv
// shift_add_mult_ctrl: iterative unsigned shift-and-add multiplier controller.
// Drives an external clock-gated ripple-carry adder (add_a/add_b/add_cin/add_en)
// and consumes its combinational sum/carry to build a 2*WIDTH-bit product,
// one multiplier bit per RUN cycle.
// Optional feature macro: SHIFT_ADD_EARLY_TERM_EN (exit RUN as soon as the
// remaining multiplier bits are all zero).
module shift_add_mult_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic               add_en,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  output logic               add_cin,
  input  logic [WIDTH-1:0]   add_sum,
  input  logic               add_cout
);

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   acc, q, m;
  logic [WIDTH-1:0]   a_hold, b_hold;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] shifted;
  logic [2*WIDTH-1:0] final_prod;
  logic               last_step;

  // Status and adder-facing outputs, decoded from state and registers.
  // When the current bit is zero the adder sees its last enabled operands,
  // so its inputs stay quiet while its clock is gated off.
  always_comb begin
    busy    = (state == RUN);
    done    = (state == DONE);
    add_en  = busy & q[0];
    add_a   = add_en ? acc : a_hold;
    add_b   = add_en ? m   : b_hold;
    add_cin = 1'b0;
  end

  // Next {ACC,Q}: take the adder result on a 1 bit, otherwise plain shift.
  always_comb begin
    if (q[0]) shifted = {add_cout, add_sum, q[WIDTH-1:1]};
    else      shifted = {1'b0, acc, q[WIDTH-1:1]};
  end

`ifdef SHIFT_ADD_EARLY_TERM_EN
  logic [WIDTH-1:0] rem_mask;
  logic [CW-1:0]    sh_amt;
  logic             rem_zero;

  // Early exit: after this step the unprocessed multiplier bits are
  // q[WIDTH-1-cnt:1]; upper q bits already hold low product bits, hence
  // the mask. The skipped zero iterations equal a right shift.
  always_comb begin
    rem_mask   = {WIDTH{1'b1}} >> (cnt + CW'(1));
    rem_zero   = ((q >> 1) & rem_mask) == '0;
    sh_amt     = LAST - cnt;
    last_step  = rem_zero | (cnt == LAST);
    final_prod = shifted >> sh_amt;
  end
`else
  // Fixed-length run: finish on the last multiplier bit.
  always_comb begin
    last_step  = (cnt == LAST);
    final_prod = shifted;
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic: IDLE -> RUN -> DONE -> IDLE; start ignored outside IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_step) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, shift/accumulate, product load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc     <= '0;
      q       <= '0;
      m       <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m   <= multiplicand;
            q   <= multiplier;
            acc <= '0;
            cnt <= '0;
          end
        end
        RUN: begin
          {acc, q} <= shifted;
          cnt      <= cnt + CW'(1);
          if (last_step) product <= final_prod;
        end
        default: ;
      endcase
    end
  end

  // Registered copies of the last operands actually presented to the adder.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_hold <= '0;
      b_hold <= '0;
    end else if (add_en) begin
      a_hold <= acc;
      b_hold <= m;
    end
  end

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Bench for shift_add_mult_ctrl: behavioural adder, product scoreboard,
// table-driven operand vectors and hand-written corner sequences.
module tb_shift_add_mult_ctrl;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   multiplicand, multiplier;
  logic           busy, done;
  logic [2*W-1:0] product;
  logic           add_en;
  logic [W-1:0]   add_a, add_b;
  logic           add_cin;
  logic [W-1:0]   add_sum;
  logic           add_cout;

  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] sb_q[$];

  shift_add_mult_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .busy(busy), .done(done), .product(product),
    .add_en(add_en), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  // Reference ripple-carry adder (combinational).
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [W-1:0] qv);
    int l;
`ifdef SHIFT_ADD_EARLY_TERM_EN
    l = 1;
    for (int i = 0; i < W; i++) if (qv[i]) l = i + 1;
`else
    l = W;
`endif
    return l;
  endfunction

  // Scoreboard: every done pulse must match the oldest expected product.
  always @(negedge clk) begin
    if (rst && done) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        chk("product", 32'(product), 32'(sb_q.pop_front()));
      end
    end
  end

  // One operation: checks latency, add_en count and operand isolation.
  // intr_cyc > 0 pulses a second start (M=1,Q=1) on that RUN cycle.
  task automatic run_op(input logic [W-1:0] mv, input logic [W-1:0] qv,
                        input logic [2*W-1:0] exp, input int intr_cyc);
    int n, en_cnt, toggles;
    logic [W-1:0] pa, pb;
    en_cnt  = 0;
    toggles = 0;
    @(negedge clk);
    multiplicand = mv; multiplier = qv; start = 1'b1;
    pa = add_a; pb = add_b;
    sb_q.push_back(exp);
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (n <= 40) begin
      if (done) break;
      if (busy) begin
        if (add_en) en_cnt++;
        else if (add_a !== pa || add_b !== pb) toggles++;
        pa = add_a; pb = add_b;
      end
      if (n == intr_cyc) begin
        start = 1'b1; multiplicand = 1; multiplier = 1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk("done_timeout", 32'(n <= 40), 32'd1);
    chk("done_cycle", 32'(n), 32'(exp_lat(qv) + 1));
    chk("add_en_count", 32'(en_cnt), 32'($countones(qv)));
    chk("isolation_toggles", 32'(toggles), 32'd0);
    @(negedge clk);
    chk("done_one_cycle", {30'd0, done, busy}, 32'd0);
    chk("product_held", 32'(product), 32'(exp));
  endtask

  typedef struct {
    logic [W-1:0]   m;
    logic [W-1:0]   q;
    logic [2*W-1:0] p;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int n, dn;
    logic [W-1:0] rm, rq;

    vecs[0] = '{8'd13,  8'd11,  16'h008F};
    vecs[1] = '{8'hFF,  8'hFF,  16'hFE01};
    vecs[2] = '{8'hA5,  8'h00,  16'h0000};
    vecs[3] = '{8'h01,  8'h01,  16'h0001};
    vecs[4] = '{8'h80,  8'h80,  16'h4000};
    vecs[5] = '{8'h12,  8'h34,  16'h03A8};
    vecs[6] = '{8'h01,  8'hFF,  16'h00FF};
    vecs[7] = '{8'hFF,  8'h80,  16'h7F80};
    vecs[8] = '{8'h05,  8'h03,  16'h000F};

    rst = 1'b0; start = 1'b0; multiplicand = '0; multiplier = '0;
    #23;
    chk("reset_busy",    32'(busy),    32'd0);
    chk("reset_done",    32'(done),    32'd0);
    chk("reset_product", 32'(product), 32'd0);
    chk("reset_add_en",  32'(add_en),  32'd0);
    chk("reset_add_a",   32'(add_a),   32'd0);
    chk("reset_add_b",   32'(add_b),   32'd0);
    chk("add_cin",       32'(add_cin), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) run_op(vecs[i].m, vecs[i].q, vecs[i].p, 0);

    for (int i = 0; i < 4; i++) begin
      rm = W'($urandom_range(0, 255));
      rq = W'($urandom_range(0, 255));
      run_op(rm, rq, {8'd0, rm} * {8'd0, rq}, 0);
    end

    // Start during RUN is ignored, then a later start in IDLE is taken.
    run_op(8'd7, 8'd9, 16'd63, 3);
    run_op(8'd1, 8'd1, 16'd1, 0);

    // Start held high: a new operation is accepted on the first IDLE edge.
    @(negedge clk);
    multiplicand = 8'd2; multiplier = 8'd3; start = 1'b1;
    sb_q.push_back(16'd6);
    n = 0;
    while (!done && n < 40) begin @(negedge clk); n++; end
    chk("held_done_timeout", 32'(n < 40), 32'd1);
    multiplicand = 8'd4; multiplier = 8'd5;
    sb_q.push_back(16'd20);
    @(negedge clk);
    chk("held_idle", {30'd0, busy, done}, 32'd0);
    @(negedge clk);
    chk("held_reaccept", 32'(busy), 32'd1);
    start = 1'b0;
    n = 0;
    while (!done && n < 40) begin @(negedge clk); n++; end
    chk("held2_done_timeout", 32'(n < 40), 32'd1);
    @(negedge clk);

    // Asynchronous reset mid-RUN abandons the operation.
    @(negedge clk);
    multiplicand = 8'd7; multiplier = 8'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_busy",    32'(busy),    32'd0);
    chk("midrst_done",    32'(done),    32'd0);
    chk("midrst_add_en",  32'(add_en),  32'd0);
    chk("midrst_product", 32'(product), 32'd0);
    chk("midrst_add_ab",  {16'd0, add_a, add_b}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    dn = 0;
    repeat (12) begin @(negedge clk); if (done) dn++; end
    chk("midrst_no_done", 32'(dn), 32'd0);
    run_op(8'd3, 8'd5, 16'd15, 0);

    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_add_mult_ctrl.md
Name: shift_add_mult_ctrl

Overview:
Iterative shift-and-add multiplier controller that sits upstream and downstream of the clock-gated ripple-carry adder stage.
- Drives the adder's operands and enable, then consumes its sum/carry to build a 2*WIDTH product over WIDTH iterations.
- add_en feeds the adder's clock-gating enable. It is asserted only on iterations whose multiplier bit is 1, so zero bits cost no adder activity.

Parameters:
WIDTH, 8, operand width; the product is 2*WIDTH bits.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
start  input  1  request; accepted only in IDLE.
multiplicand  input  WIDTH  operand M, sampled on the accepting edge.
multiplier  input  WIDTH  operand Q, sampled on the accepting edge.
busy  output  1  high while in RUN.
done  output  1  one-cycle pulse; product is valid.
product  output  2*WIDTH  result, held until the next accepted start.
add_en  output  1  adder/clock-gate enable.
add_a  output  WIDTH  adder operand a (accumulator).
add_b  output  WIDTH  adder operand b (multiplicand).
add_cin  output  1  adder carry-in, tied 0.
add_sum  input  WIDTH  adder sum; combinational, valid in the same cycle.
add_cout  input  1  adder carry-out.

Behaviour:
- Registers: ACC[WIDTH], Q[WIDTH], M[WIDTH], cnt[clog2(WIDTH+1)], product[2W], state.
- Reset (rst=0, asynchronous): state=IDLE; ACC, Q, M, cnt, product = 0; busy=0; done=0; add_en=0; add_a=0; add_b=0.
- FSM states: IDLE -> RUN -> DONE -> IDLE.
- IDLE, start=1 at an edge:
  - M<=multiplicand, Q<=multiplier, ACC<=0, cnt<=0.
  - go to RUN.
- RUN, one multiplier bit per cycle:
  - add_en=Q[0]. add_a=ACC, add_b=M, both driven combinationally from the registers.
  - If Q[0]=1: at the edge, {ACC,Q} <= {add_cout, add_sum, Q[W-1:1]}.
  - If Q[0]=0: at the edge, {ACC,Q} <= {1'b0, ACC, Q[W-1:1]}; adder outputs are ignored.
  - cnt increments each cycle.
  - When cnt==WIDTH-1, at that edge: load product with the shifted {ACC,Q} value and go to DONE.
- Operand isolation: add_a and add_b are muxed so that when add_en=0 they hold their last enabled values (registered copies). Adder inputs do not toggle on skipped iterations.
- DONE: done=1 for exactly one cycle, then IDLE. busy=0.
- Latency:
  - start accepted at edge E0; RUN spans cycles E0..E0+WIDTH.
  - done is high in the cycle after edge E0+WIDTH; product is valid from that same edge.
- start while in RUN or DONE is ignored; no queueing.
- start held high continuously: a new operation is accepted on the first edge back in IDLE.
- Arithmetic is unsigned; no overflow is possible, since 2W bits always suffice.
- Reset asserted mid-RUN: the operation is abandoned, all outputs return to reset values, no done pulse.

Optional Feature:
Macro: SHIFT_ADD_EARLY_TERM_EN
- Defined:
  - Each RUN cycle checks the remaining unprocessed multiplier bits (Q[W-1-cnt:0] after the current step).
  - If all are zero, it finishes that edge with product <= {ACC,Q} >> (WIDTH-cnt-1) and goes to DONE.
  - Latency becomes (index of highest set bit + 1) RUN cycles; multiplier=0 takes 1 RUN cycle.
  - Result is identical to the full run.
- Undefined: fixed WIDTH-cycle RUN as above; no early-exit logic is synthesized.

Test Plan:
1. WIDTH=8, M=13, Q=11 -> product=0x008F.
   - done pulses exactly 9 cycles after the accepting edge.
   - add_en high on exactly 3 RUN cycles.
2. M=255, Q=255 -> product=0xFE01.
   - add_cout=1 is captured into ACC on the final iterations; no truncation.
3. M=0xA5, Q=0 -> product=0.
   - add_en never asserts.
   - add_a/add_b do not toggle during RUN.
4. Start M=7, Q=9, then pulse start again at RUN cycle 3 with M=1, Q=1 -> second start ignored; product=63.
   - A later start in IDLE with M=1, Q=1 -> product=1.
5. rst driven low at RUN cycle 4, asynchronously mid-cycle -> busy, done, add_en and product go to 0 immediately.
   - A fresh start with M=3, Q=5 -> product=15.
6. With SHIFT_ADD_EARLY_TERM_EN: M=5, Q=3 -> product=15 after 2 RUN cycles.
   - Q=0 -> done after 1 RUN cycle, product=0.
   - Q=0x80 -> full 8 cycles.
